// File: rtl/processor_parametros_entrada_if.sv
// Processor-side Avalon-MM write slave and Avalon-ST source bundle for the
// parameter input bridge. The slave modport is the bridge's view.
interface processor_parametros_entrada_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  avalonmm_write_slave_address;
  logic                  avalonmm_write_slave_write;
  logic [31:0]           avalonmm_write_slave_writedata;
  logic                  avalonmm_write_slave_read;
  logic [31:0]           avalonmm_write_slave_readdata;
  logic [DATA_WIDTH-1:0] avalonst_source_data;
  logic                  avalonst_source_valid;
  logic                  avalonst_source_ready;

  modport slave (
    input  avalonmm_write_slave_address,
    input  avalonmm_write_slave_write,
    input  avalonmm_write_slave_writedata,
    input  avalonmm_write_slave_read,
    output avalonmm_write_slave_readdata,
    output avalonst_source_data,
    output avalonst_source_valid,
    input  avalonst_source_ready
  );

  modport master (
    output avalonmm_write_slave_address,
    output avalonmm_write_slave_write,
    output avalonmm_write_slave_writedata,
    output avalonmm_write_slave_read,
    input  avalonmm_write_slave_readdata,
    input  avalonst_source_data,
    input  avalonst_source_valid,
    output avalonst_source_ready
  );
endinterface

// File: rtl/processor_parametros_entrada.sv
// Processor-to-stream bridge: MM word writes are buffered in a FIFO and
// presented first-word-fall-through on an Avalon-ST source.
module processor_parametros_entrada #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic wrclock,
  input  logic reset,
  processor_parametros_entrada_if.slave bus
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_rd_ptr;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW:0]           r_count;
  logic                  r_overflow;
  logic [31:0]           r_readdata;

  logic        w_full;
  logic        w_empty;
  logic        w_data_wr;
  logic        w_ctrl_wr;
  logic        w_push;
  logic        w_pop;
  logic        w_flush;
  logic        w_clr_ovf;
  logic        w_set_ovf;
  logic [31:0] w_status;

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_data_wr = bus.avalonmm_write_slave_write & ~bus.avalonmm_write_slave_address;
  assign w_ctrl_wr = bus.avalonmm_write_slave_write &  bus.avalonmm_write_slave_address;
  // A write into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign w_push    = w_data_wr & ~w_full;
  assign w_set_ovf = w_data_wr &  w_full;
  assign w_pop     = ~w_empty & bus.avalonst_source_ready;
  assign w_flush   = w_ctrl_wr & bus.avalonmm_write_slave_writedata[0];
  assign w_clr_ovf = w_ctrl_wr & bus.avalonmm_write_slave_writedata[1];

  always_comb begin
    w_status       = '0;
    w_status[AW:0] = r_count;
    w_status[16]   = w_empty;
    w_status[17]   = w_full;
    w_status[24]   = r_overflow;
  end

  // Storage has no reset; only the pointers/count define which words are live.
  always_ff @(posedge wrclock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= DATA_WIDTH'(bus.avalonmm_write_slave_writedata);
    end
  end

  always_ff @(posedge wrclock or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge wrclock or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_clr_ovf) begin
      r_overflow <= 1'b0;
    end else if (w_set_ovf) begin
      r_overflow <= 1'b1;
    end
  end

  // Status is captured from the pre-update state of the read cycle.
  always_ff @(posedge wrclock or posedge reset) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (bus.avalonmm_write_slave_read) begin
      r_readdata <= bus.avalonmm_write_slave_address ? w_status : 32'h0;
    end
  end

  assign bus.avalonmm_write_slave_readdata = r_readdata;
  assign bus.avalonst_source_valid         = ~w_empty;
  assign bus.avalonst_source_data          = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: tb/tb_processor_parametros_entrada.sv
// Scoreboard bench: expected stream words and status reads are queued by the
// stimulus; a negedge monitor pops and compares them as the DUT produces them.
module tb_processor_parametros_entrada;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  processor_parametros_entrada_if #(.DATA_WIDTH(32)) bus ();

  processor_parametros_entrada #(
    .DATA_WIDTH(32), .DEPTH(16), .AW(4)
  ) dut (
    .wrclock (clk),
    .reset   (rst),
    .bus     (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q [$];
  logic [31:0] rd_q  [$];
  logic        rd_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end else begin
      $display("ok   %s value=0x%08h", name, act);
    end
  endtask

  // Monitor: stream handshakes and read-latency-1 status responses.
  always @(negedge clk) begin
    if (rst) begin
      rd_pending = 1'b0;
    end else begin
      if (rd_pending) begin
        if (rd_q.size() == 0) check("unexpected_readdata", 32'h1, 32'h0);
        else check("status_read", bus.avalonmm_write_slave_readdata, rd_q.pop_front());
      end
      rd_pending = bus.avalonmm_write_slave_read;
      if (bus.avalonst_source_valid && bus.avalonst_source_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", bus.avalonst_source_data, 32'hFFFF_FFFF);
        else check("stream_word", bus.avalonst_source_data, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mm_write(input logic addr, input logic [31:0] data, input bit expect_push);
    bus.avalonmm_write_slave_address   = addr;
    bus.avalonmm_write_slave_write     = 1'b1;
    bus.avalonmm_write_slave_writedata = data;
    if (expect_push) exp_q.push_back(data);
    step();
    bus.avalonmm_write_slave_write   = 1'b0;
    bus.avalonmm_write_slave_address = 1'b0;
  endtask

  task automatic rd_status(input logic [31:0] expected);
    bus.avalonmm_write_slave_address = 1'b1;
    bus.avalonmm_write_slave_read    = 1'b1;
    rd_q.push_back(expected);
    step();
    bus.avalonmm_write_slave_read    = 1'b0;
    bus.avalonmm_write_slave_address = 1'b0;
  endtask

  task automatic drain(input int cycles);
    bus.avalonst_source_ready = 1'b1;
    repeat (cycles) step();
    bus.avalonst_source_ready = 1'b0;
  endtask

  initial begin
    bus.avalonmm_write_slave_address   = 1'b0;
    bus.avalonmm_write_slave_write     = 1'b0;
    bus.avalonmm_write_slave_writedata = '0;
    bus.avalonmm_write_slave_read      = 1'b0;
    bus.avalonst_source_ready          = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", {31'b0, bus.avalonst_source_valid}, 32'h0);
    check("reset_data", bus.avalonst_source_data, 32'h0);
    check("reset_readdata", bus.avalonmm_write_slave_readdata, 32'h0);
    rst = 1'b0;
    step();

    // Three words with the sink stalled.
    for (int i = 1; i <= 3; i++) mm_write(1'b0, 32'hA5A5_0000 + 32'(i), 1'b1);
    check("fwft_valid", {31'b0, bus.avalonst_source_valid}, 32'h1);
    check("fwft_data", bus.avalonst_source_data, 32'hA5A5_0001);
    rd_status(32'h0000_0003);

    drain(3);
    check("valid_after_drain", {31'b0, bus.avalonst_source_valid}, 32'h0);
    rd_status(32'h0001_0000);

    // Overflow: 17 writes into a 16-deep FIFO; word 16 must vanish.
    for (int i = 0; i <= 16; i++) mm_write(1'b0, 32'(i), i < 16);
    rd_status(32'h0102_0010);
    drain(18);
    check("ovf_drain_left", 32'(exp_q.size()), 32'h0);
    rd_status(32'h0101_0000);
    mm_write(1'b1, 32'h2, 1'b0);
    rd_status(32'h0001_0000);

    // Write to a full FIFO in the same cycle as a pop: no bypass.
    for (int i = 0; i < 16; i++) mm_write(1'b0, 32'h100 + 32'(i), 1'b1);
    bus.avalonst_source_ready = 1'b1;
    mm_write(1'b0, 32'hDEAD_BEEF, 1'b0);
    bus.avalonst_source_ready = 1'b0;
    rd_status(32'h0100_000F);
    drain(16);
    mm_write(1'b1, 32'h2, 1'b0);
    rd_status(32'h0001_0000);

    // Steady push+pop at count 5 across pointer wrap.
    for (int i = 0; i < 5; i++) mm_write(1'b0, 32'h200 + 32'(i), 1'b1);
    bus.avalonst_source_ready = 1'b1;
    for (int i = 0; i < 40; i++) mm_write(1'b0, 32'h300 + 32'(i), 1'b1);
    bus.avalonst_source_ready = 1'b0;
    rd_status(32'h0000_0005);
    drain(6);
    rd_status(32'h0001_0000);

    // Flush with the sink ready: the pending pop is overridden.
    for (int i = 0; i < 7; i++) mm_write(1'b0, 32'h400 + 32'(i), 1'b1);
    rd_status(32'h0000_0007);
    bus.avalonst_source_ready = 1'b1;
    mm_write(1'b1, 32'h1, 1'b0);
    exp_q.delete();
    check("flush_valid", {31'b0, bus.avalonst_source_valid}, 32'h0);
    bus.avalonst_source_ready = 1'b0;
    rd_status(32'h0001_0000);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 4; i++) mm_write(1'b0, 32'h500 + 32'(i), 1'b1);
    rd_status(32'h0000_0004);
    step();
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, bus.avalonst_source_valid}, 32'h0);
    check("async_rst_data", bus.avalonst_source_data, 32'h0);
    check("async_rst_readdata", bus.avalonmm_write_slave_readdata, 32'h0);
    exp_q.delete();
    rd_q.delete();
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 2; i++) mm_write(1'b0, 32'h600 + 32'(i), 1'b1);
    check("restart_data", bus.avalonst_source_data, 32'h0000_0600);
    drain(3);
    rd_status(32'h0001_0000);

    repeat (3) step();
    check("stream_queue_empty", 32'(exp_q.size()), 32'h0);
    check("status_queue_empty", 32'(rd_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
